sim_step_sequencer: RTL and testbench

//  Top-level scheduler for the fluid pipeline. Each frame tick, it runs a fixed

---
 rtl/sim_step_sequencer_if.sv | 11 +
 rtl/sim_step_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sim_step_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_step_sequencer_if.sv
// Start/done handshake between the step sequencer and the pipeline stages.
// The sequencer owns the one-hot start pulses; each stage returns its own done bit.
interface sim_step_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_done;

    modport master (output stage_start, input stage_done);
    modport slave  (input stage_start, output stage_done);
endinterface

// File: rtl/sim_step_sequencer.sv
// Frame scheduler: on each accepted frame tick, runs the stage chain STEPS_PER_FRAME
// times, one start/done handshake at a time, with overrun tracking and a stage watchdog.
module sim_step_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int STEPS_PER_FRAME = 2,
    parameter int TIMEOUT         = 4096,
    parameter int CNTW            = 16,
    localparam int SW             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int PW             = $clog2(STEPS_PER_FRAME) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    frame_tick,
    input  logic                    clear_fault,
    sim_step_sequencer_if.master    stages,
    output logic                    busy,
    output logic [SW-1:0]           cur_stage,
    output logic [PW-1:0]           cur_step,
    output logic                    frame_done,
    output logic [CNTW-1:0]         frame_count,
    output logic                    overrun,
    output logic [CNTW-1:0]         overrun_count,
    output logic                    fault,
    output logic [SW-1:0]           fault_stage
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                 state_reg, state_next;
    logic [SW-1:0]          stage_reg, stage_next;
    logic [PW-1:0]          step_reg, step_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic [NUM_STAGES-1:0]  start_reg, start_next;
    logic                   busy_reg, busy_next;
    logic                   frame_done_reg, frame_done_next;
    logic [CNTW-1:0]        frame_count_reg, frame_count_next;
    logic                   overrun_reg, overrun_next;
    logic [CNTW-1:0]        overrun_count_reg, overrun_count_next;
    logic                   fault_reg, fault_next;
    logic [SW-1:0]          fault_stage_reg, fault_stage_next;

    logic [NUM_STAGES-1:0]  done_hit;
    logic                   done_active;

    // Only the active stage's done bit is observed; the others are masked off.
    // Start pulses are decoded from the next state so they line up with LAUNCH.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign done_hit[gi]   = stages.stage_done[gi] && (stage_reg == SW'(gi));
            assign start_next[gi] = (state_next == S_LAUNCH) && (stage_next == SW'(gi));
        end
    endgenerate

    assign done_active = |done_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= S_IDLE;
            stage_reg         <= '0;
            step_reg          <= '0;
            timer_reg         <= '0;
            start_reg         <= '0;
            busy_reg          <= 1'b0;
            frame_done_reg    <= 1'b0;
            frame_count_reg   <= '0;
            overrun_reg       <= 1'b0;
            overrun_count_reg <= '0;
            fault_reg         <= 1'b0;
            fault_stage_reg   <= '0;
        end else begin
            state_reg         <= state_next;
            stage_reg         <= stage_next;
            step_reg          <= step_next;
            timer_reg         <= timer_next;
            start_reg         <= start_next;
            busy_reg          <= busy_next;
            frame_done_reg    <= frame_done_next;
            frame_count_reg   <= frame_count_next;
            overrun_reg       <= overrun_next;
            overrun_count_reg <= overrun_count_next;
            fault_reg         <= fault_next;
            fault_stage_reg   <= fault_stage_next;
        end
    end

    // A done arriving on the watchdog's last cycle still wins over the timeout.
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        step_next  = step_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (frame_tick && enable) begin
                    state_next = S_LAUNCH;
                    stage_next = '0;
                    step_next  = '0;
                end
            end
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                if (done_active) begin
                    if (stage_reg != SW'(NUM_STAGES - 1)) begin
                        stage_next = stage_reg + 1'b1;
                        state_next = S_LAUNCH;
                    end else if (step_reg != PW'(STEPS_PER_FRAME - 1)) begin
                        step_next  = step_reg + 1'b1;
                        stage_next = '0;
                        state_next = S_LAUNCH;
                    end else begin
                        state_next = S_DONE;
                    end
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    state_next = S_FAULT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_FAULT: begin
                if (clear_fault) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The timer reads 0 during LAUNCH and counts every cycle spent in WAIT.
    always_comb begin
        timer_next         = (state_next == S_WAIT) ? timer_reg + 1'b1 : '0;
        busy_next          = (state_next != S_IDLE);
        frame_done_next    = (state_next == S_DONE);
        frame_count_next   = frame_count_reg;
        overrun_next       = overrun_reg;
        overrun_count_next = overrun_count_reg;
        fault_next         = (state_next == S_FAULT);
        fault_stage_next   = fault_stage_reg;

        if (state_next == S_DONE) frame_count_next = frame_count_reg + 1'b1;

        if (frame_tick && (state_reg != S_IDLE)) begin
            overrun_next = 1'b1;
            if (overrun_count_reg != '1) overrun_count_next = overrun_count_reg + 1'b1;
        end

        if ((state_reg == S_WAIT) && (state_next == S_FAULT))
            fault_stage_next = stage_reg;
        else if ((state_reg == S_FAULT) && (state_next == S_IDLE))
            fault_stage_next = '0;
    end

    assign stages.stage_start = start_reg;
    assign busy               = busy_reg;
    assign cur_stage          = stage_reg;
    assign cur_step           = step_reg;
    assign frame_done         = frame_done_reg;
    assign frame_count        = frame_count_reg;
    assign overrun            = overrun_reg;
    assign overrun_count      = overrun_count_reg;
    assign fault              = fault_reg;
    assign fault_stage        = fault_stage_reg;
endmodule

// File: tb/tb_sim_step_sequencer.sv
// Self-checking bench: randomized stage latencies, expected start/done timing
// computed from the chain's timing rules, with directed overrun, fault and reset cases.
module tb_sim_step_sequencer;
    localparam int NS      = 3;
    localparam int SPF     = 2;
    localparam int TO      = 16;
    localparam int CW      = 16;
    localparam int NSTARTS = NS * SPF;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk         = 1'b0;
    logic          reset       = 1'b0;
    logic          enable      = 1'b0;
    logic          frame_tick  = 1'b0;
    logic          clear_fault = 1'b0;
    logic          busy, frame_done, overrun, fault;
    logic [1:0]    cur_stage, fault_stage, cur_step;
    logic [CW-1:0] frame_count, overrun_count;

    sim_step_sequencer_if #(.NUM_STAGES(NS)) bus ();

    sim_step_sequencer #(
        .NUM_STAGES(NS), .STEPS_PER_FRAME(SPF), .TIMEOUT(TO), .CNTW(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .clear_fault(clear_fault), .stages(bus), .busy(busy),
        .cur_stage(cur_stage), .cur_step(cur_step), .frame_done(frame_done),
        .frame_count(frame_count), .overrun(overrun), .overrun_count(overrun_count),
        .fault(fault), .fault_stage(fault_stage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int lat [NS];              // stage latency in cycles; 0 means the stage hangs
    int stray_cyc = -1;
    logic [NS-1:0] stray_bits = '0;
    int st_stage[$], st_cur[$], st_step[$], st_cyc[$], st_hot[$], fd_cyc[$];
    int exp_frames = 0;
    int exp_ovr    = 0;
    logic exp_ovf  = 1'b0;
    int frame_id   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        st_stage.delete(); st_cur.delete(); st_step.delete();
        st_cyc.delete(); st_hot.delete(); fd_cyc.delete();
    endtask

    // Stage model: answers each start with a one-cycle done lat[i] cycles later.
    initial begin : responder
        int pend [NS];
        logic [NS-1:0] nd;
        for (int i = 0; i < NS; i++) pend[i] = -1;
        bus.stage_done = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                for (int i = 0; i < NS; i++) pend[i] = -1;
            end else begin
                for (int i = 0; i < NS; i++) begin
                    if (bus.stage_start[i] === 1'b1) begin
                        st_stage.push_back(i);
                        st_cur.push_back(int'(cur_stage));
                        st_step.push_back(int'(cur_step));
                        st_cyc.push_back(cyc);
                        st_hot.push_back($countones(bus.stage_start));
                        pend[i] = (lat[i] > 0) ? cyc + lat[i] : -1;
                    end
                end
            end
            if (frame_done === 1'b1) fd_cyc.push_back(cyc);
            nd = '0;
            for (int i = 0; i < NS; i++) if (pend[i] == cyc) nd[i] = 1'b1;
            if (cyc == stray_cyc) nd = nd | stray_bits;
            bus.stage_done = nd;
        end
    end

    task automatic randomize_lat(input int lo, input int hi);
        for (int i = 0; i < NS; i++) lat[i] = $urandom_range(hi, lo);
    endtask

    // One complete frame; inject adds a tick while busy and drops enable mid-frame,
    // stray pulses the last stage's done while stage 0 is still waiting.
    task automatic run_frame(input bit inject, input bit stray);
        int t, t0, n, off;
        int exp_cyc [NSTARTS];
        clear_log();
        off = $urandom_range(10, 2);
        @(negedge clk);
        if (stray) begin
            stray_cyc  = cyc + 4;
            stray_bits = NS'(1 << (NS - 1));
        end
        frame_tick = 1'b1;
        t0 = cyc + 1;
        t  = t0;
        for (int k = 0; k < NSTARTS; k++) begin
            exp_cyc[k] = t;
            t = t + lat[k % NS] + 1;
        end
        @(negedge clk);
        frame_tick = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            frame_tick = inject && (n == off);
            if (inject && n == off + 1) enable = 1'b0;
            @(negedge clk);
            n++;
        end
        frame_tick = 1'b0;
        enable     = 1'b1;
        stray_cyc  = -1;
        exp_frames++;
        if (inject) begin
            exp_ovf = 1'b1;
            if (exp_ovr != CMAX) exp_ovr++;
        end
        check("frame_end_in_time", n < 2000, 1);
        check("start_count", st_stage.size(), NSTARTS);
        for (int k = 0; k < st_stage.size() && k < NSTARTS; k++) begin
            check("start_stage", st_stage[k], k % NS);
            check("start_cycle", st_cyc[k], exp_cyc[k]);
            check("start_onehot", st_hot[k], 1);
            check("cur_stage", st_cur[k], k % NS);
            check("cur_step", st_step[k], k / NS);
        end
        check("frame_done_count", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) check("frame_done_cycle", fd_cyc[0], t);
        check("frame_count", frame_count, exp_frames % (CMAX + 1));
        check("overrun", overrun, exp_ovf);
        check("overrun_count", overrun_count, exp_ovr);
        check("fault_clear", fault, 0);
        frame_id++;
        $display("frame %0d: tick@%0d lat=%0d/%0d/%0d inject=%0d stray=%0d frame_count=%0d overrun_count=%0d",
                 frame_id, t0 - 1, lat[0], lat[1], lat[2], inject, stray, frame_count, overrun_count);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        exp_frames = 0;
        exp_ovr    = 0;
        exp_ovf    = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int t0, n, exp_fault;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_start", bus.stage_start, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fault", fault, 0);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Fixed latency of 5 on every stage
        lat = '{5, 5, 5};
        run_frame(1'b0, 1'b0);
        check("first_frame_count", frame_count, 1);
        check("idle_after_frame", busy, 0);

        randomize_lat(1, 6);
        run_frame(1'b1, 1'b0);
        randomize_lat(1, 6);
        lat[0] = $urandom_range(8, 5);
        run_frame(1'b0, 1'b1);
        for (int f = 0; f < 6; f++) begin
            randomize_lat(1, 6);
            run_frame(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Tick with enable low is ignored outright
        clear_log();
        enable     = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        check("en0_busy", busy, 0);
        check("en0_starts", st_stage.size(), 0);
        check("en0_overrun", overrun, exp_ovf);
        check("en0_overrun_count", overrun_count, exp_ovr);
        enable = 1'b1;

        // Last stage hangs: watchdog fault
        randomize_lat(1, 6);
        lat[2] = 0;
        clear_log();
        frame_tick = 1'b1;
        t0 = cyc + 1;
        exp_fault = t0 + lat[0] + 1 + lat[1] + 1 + TO;
        @(negedge clk);
        frame_tick = 1'b0;
        n = 0;
        while (fault !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("fault_seen", fault, 1);
        check("fault_cycle", cyc, exp_fault);
        check("fault_stage", fault_stage, 2);
        check("fault_busy", busy, 1);
        repeat (5) @(negedge clk);
        check("fault_no_more_starts", st_stage.size(), 3);
        check("fault_sticky", fault, 1);
        check("fault_no_frame_done", fd_cyc.size(), 0);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        check("clear_fault", fault, 0);
        check("clear_fault_stage", fault_stage, 0);
        check("clear_busy", busy, 0);
        $display("fault: stage 2 hung, fault@%0d cleared", exp_fault);
        randomize_lat(1, 6);
        run_frame(1'b0, 1'b0);

        // Reset in the middle of stage 0's wait
        lat = '{8, 3, 3};
        clear_log();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat ($urandom_range(5, 1)) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_start", bus.stage_start, 0);
        check("mid_rst_cur_stage", cur_stage, 0);
        check("mid_rst_cur_step", cur_step, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_frame_count", frame_count, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_overrun_count", overrun_count, 0);
        check("mid_rst_fault", fault, 0);
        check("mid_rst_fault_stage", fault_stage, 0);
        @(negedge clk);
        reset      = 1'b1;
        exp_frames = 0;
        exp_ovr    = 0;
        exp_ovf    = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_no_frame_done", fd_cyc.size(), 0);
        $display("reset: frame abandoned mid-wait");
        randomize_lat(1, 6);
        run_frame(1'b0, 1'b0);

        // Back-to-back minimum-length frames
        apply_reset();
        lat = '{1, 1, 1};
        for (int f = 0; f < 300; f++) run_frame(1'b0, 1'b0);
        check("frames_300", frame_count, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
